// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory handshake plus the decoded instruction
// handed to the datapath. The master side is the fetch unit.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic        br_taken;
  logic        jump;
  logic [31:0] inst;
  logic [15:0] imm16;
  logic        ext_sel;
  logic [31:0] pc_plus4;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, imm16, ext_sel, pc_plus4,
    input  imem_ack, imem_rdata, inst_ready, br_taken, jump
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, imm16, ext_sel, pc_plus4,
    output imem_ack, imem_rdata, inst_ready, br_taken, jump
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one word per req/ack
// transaction and redirects on branch/jump when downstream accepts.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] pc_r;
  logic [31:0] ir_r;
  logic [31:0] pc_nxt_s;
  logic [31:0] ir_nxt_s;
  logic [31:0] pc_plus4_s;
  logic [31:0] br_target_s;
  logic [31:0] jmp_target_s;
  logic [31:0] next_pc_s;

  // Logical-immediate opcodes (andi/ori/xori/lui) zero-extend; all others sign-extend.
  function automatic logic ext_sel_f(input logic [5:0] opcode);
    case (opcode)
      6'h0C, 6'h0D, 6'h0E, 6'h0F: ext_sel_f = 1'b0;
      default:                    ext_sel_f = 1'b1;
    endcase
  endfunction

  assign pc_plus4_s   = pc_r + 32'd4;
  assign br_target_s  = pc_plus4_s + {{14{ir_r[15]}}, ir_r[15:0], 2'b00};
  assign jmp_target_s = {pc_plus4_s[31:28], ir_r[25:0], 2'b00};

  // Redirect priority: jump over taken branch over sequential.
  always_comb begin
    next_pc_s = pc_plus4_s;
    if (bus.jump) begin
      next_pc_s = jmp_target_s;
    end else if (bus.br_taken) begin
      next_pc_s = br_target_s;
    end else begin
      next_pc_s = pc_plus4_s;
    end
  end

  // State register: FSM state, PC and instruction register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= FETCH;
      pc_r    <= RESET_PC;
      ir_r    <= 32'h0000_0000;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      ir_r    <= ir_nxt_s;
    end
  end

  // Next-state logic: capture on ack in FETCH, advance PC on ready in HOLD.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    ir_nxt_s    = ir_r;
    case (state_r)
      FETCH: begin
        if (bus.imem_ack) begin
          ir_nxt_s    = bus.imem_rdata;
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = FETCH;
        end
      end
      HOLD: begin
        if (bus.inst_ready) begin
          pc_nxt_s    = next_pc_s;
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = FETCH;
      end
    endcase
  end

  // Outputs: request is suppressed while reset is asserted.
  always_comb begin
    bus.imem_req   = (state_r == FETCH) & rst_n;
    bus.imem_addr  = pc_r;
    bus.inst_valid = (state_r == HOLD);
    bus.inst       = ir_r;
    bus.imm16      = ir_r[15:0];
    bus.ext_sel    = ext_sel_f(ir_r[31:26]);
    bus.pc_plus4   = pc_plus4_s;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// handshake traffic, all compared against a transaction-level PC/IR model.
module tb_fetch_unit;

  logic clk;
  logic rst_n;
  logic rst2_n;

  fetch_unit_if bus ();
  fetch_unit_if bus2 ();

  fetch_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk   (clk),
    .rst_n (rst2_n),
    .bus   (bus2.master)
  );

  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  int check_count;
  int error_count;

  // reference model: architectural PC, instruction word, and "instruction pending" flag
  logic [31:0] m_pc;
  logic [31:0] m_ir;
  bit          m_valid;
  bit          m_known;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_next(input bit br, input bit jmp);
    logic [31:0]        pc4;
    logic signed [31:0] offset;
    pc4    = m_pc + 32'd4;
    offset = $signed(m_ir[15:0]);
    if (jmp) return {pc4[31:28], m_ir[25:0], 2'b00};
    if (br) return pc4 + 32'(offset * 4);
    return pc4;
  endfunction

  function automatic bit model_ext(input logic [31:0] word);
    int op;
    op = int'(word[31:26]);
    return !(op >= 12 && op <= 15);
  endfunction

  task automatic step(input bit rst, input bit ack, input logic [31:0] rdata,
                      input bit ready, input bit br, input bit jmp);
    rst_n           = rst;
    bus.imem_ack    = ack;
    bus.imem_rdata  = rdata;
    bus.inst_ready  = ready;
    bus.br_taken    = br;
    bus.jump        = jmp;
    #1;
    if (m_known) begin
      check_val("imem_req",   {31'd0, bus.imem_req},   {31'd0, rst & ~m_valid});
      check_val("imem_addr",  bus.imem_addr,           m_pc);
      check_val("inst_valid", {31'd0, bus.inst_valid}, {31'd0, m_valid});
      check_val("inst",       bus.inst,                m_ir);
      check_val("imm16",      {16'd0, bus.imm16},      {16'd0, m_ir[15:0]});
      check_val("ext_sel",    {31'd0, bus.ext_sel},    {31'd0, model_ext(m_ir)});
      check_val("pc_plus4",   bus.pc_plus4,            m_pc + 32'd4);
    end
    @(posedge clk);
    if (!rst) begin
      m_pc    = RESET_PC;
      m_ir    = 32'h0000_0000;
      m_valid = 1'b0;
      m_known = 1'b1;
    end else if (!m_valid) begin
      if (ack) begin
        m_ir    = rdata;
        m_valid = 1'b1;
      end
    end else if (ready) begin
      m_pc    = model_next(br, jmp);
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic fetch_accept(input logic [31:0] word, input bit br, input bit jmp);
    step(1'b1, 1'b1, word, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0000_0000, 1'b1, br, jmp);
  endtask

  initial begin
    logic [31:0] rword;
    check_count = 0;
    error_count = 0;
    m_known     = 1'b0;
    m_valid     = 1'b0;
    m_pc        = 32'h0000_0000;
    m_ir        = 32'h0000_0000;
    rst_n       = 1'b0;
    rst2_n      = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0; bus.inst_ready = 1'b0;
    bus.br_taken = 1'b0; bus.jump = 1'b0;
    bus2.imem_ack = 1'b0; bus2.imem_rdata = 32'h0; bus2.inst_ready = 1'b0;
    bus2.br_taken = 1'b0; bus2.jump = 1'b0;
    @(negedge clk);

    // reset, including a same-cycle ack that must be discarded
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    check_val("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
    check_val("rst_inst",  bus.inst,                32'd0);
    check_val("rst_imm16", {16'd0, bus.imm16},      32'd0);
    check_val("rst_ext",   {31'd0, bus.ext_sel},    32'd1);
    check_val("rst_pc4",   bus.pc_plus4,            32'h0040_0004);
    check_val("rst_addr",  bus.imem_addr,           32'h0040_0000);

    // sequential fetch
    for (int i = 0; i < 4; i++) begin
      check_val("seq_addr", bus.imem_addr, 32'h0040_0000 + 32'(i * 4));
      fetch_accept(32'h0000_0000, 1'b0, 1'b0);
    end
    check_val("seq_addr", bus.imem_addr, 32'h0040_0010);

    // branch taken / not taken
    fetch_accept(32'h1000_FFFE, 1'b1, 1'b0);
    check_val("br_taken_addr", bus.imem_addr, 32'h0040_000C);
    fetch_accept(32'h0000_0000, 1'b0, 1'b0);
    fetch_accept(32'h1000_FFFE, 1'b0, 1'b0);
    check_val("br_not_taken_addr", bus.imem_addr, 32'h0040_0014);

    // jump wins over branch
    for (int i = 0; i < 3; i++) fetch_accept(32'h0000_0000, 1'b0, 1'b0);
    check_val("pre_jump_addr", bus.imem_addr, 32'h0040_0020);
    fetch_accept(32'h0810_0040, 1'b1, 1'b1);
    check_val("jump_addr", bus.imem_addr, 32'h0040_0100);

    // extender select
    step(1'b1, 1'b1, 32'h3421_FFFF, 1'b0, 1'b0, 1'b0);
    check_val("ori_imm16", {16'd0, bus.imm16}, 32'h0000_FFFF);
    check_val("ori_ext",   {31'd0, bus.ext_sel}, 32'd0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h2021_FFFF, 1'b0, 1'b0, 1'b0);
    check_val("addi_ext", {31'd0, bus.ext_sel}, 32'd1);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h3C01_ABCD, 1'b0, 1'b0, 1'b0);
    check_val("lui_ext", {31'd0, bus.ext_sel}, 32'd0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // slow memory then backpressure with toggling branch
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'h1234_5678, 1'b0, 1'b1, 1'b1);
      check_val("slow_addr", bus.imem_addr, 32'h0040_010C);
      check_val("slow_req",  {31'd0, bus.imem_req}, 32'd1);
    end
    step(1'b1, 1'b1, 32'h1000_0005, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, i[0], 1'b0);
      check_val("bp_inst", bus.inst,     32'h1000_0005);
      check_val("bp_pc4",  bus.pc_plus4, 32'h0040_0110);
    end
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check_val("bp_next_addr", bus.imem_addr, 32'h0040_0110);

    // reset while holding with ack asserted
    step(1'b1, 1'b1, 32'h2021_0001, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'hCAFE_0000, 1'b0, 1'b1, 1'b1);
    check_val("midrst_valid", {31'd0, bus.inst_valid}, 32'd0);
    check_val("midrst_inst",  bus.inst,                32'd0);
    check_val("midrst_addr",  bus.imem_addr,           32'h0040_0000);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      rword = $urandom;
      if ($urandom_range(0, 2) == 0) rword[31:26] = 6'h0C + 6'($urandom_range(0, 3));
      step($urandom_range(0, 49) != 0, $urandom_range(0, 1) == 1, rword,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
    end

    // PC wrap on an instance reset at the top of the address space
    check_val("wrap_rst_pc4",  bus2.pc_plus4,  32'h0000_0000);
    check_val("wrap_rst_addr", bus2.imem_addr, 32'hFFFF_FFFC);
    rst2_n = 1'b1;
    bus2.imem_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("wrap_valid", {31'd0, bus2.inst_valid}, 32'd1);
    bus2.imem_ack   = 1'b0;
    bus2.inst_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("wrap_addr", bus2.imem_addr, 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the processor datapath. Holds the PC and fetches one 32-bit instruction per transaction from instruction memory over a req/ack handshake, then presents it with its immediate field and extension-select to the 16→32 extender. It computes the next PC: sequential, branch (PC+4 + sign-extended imm16 << 2) or jump (26-bit target), applied only when downstream accepts the instruction.

## Interface
- RESET_PC, 32'h0040_0000, PC loaded on reset; must be word-aligned.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; equals current PC; bits [1:0] always 0.
- imem_ack  in  1  memory response; imem_rdata valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- inst_valid  out  1  instruction register holds a valid, unconsumed instruction.
- inst_ready  in  1  downstream accepts the instruction this cycle.
- br_taken  in  1  branch condition resolved true; sampled only at acceptance.
- jump  in  1  current instruction is a J-type jump; sampled only at acceptance.
- inst  out  32  instruction register contents.
- imm16  out  16  inst[15:0], feeds the extender input.
- ext_sel  out  1  extender select: 1 = sign-extend, 0 = zero-extend.
- pc_plus4  out  32  PC + 4 (modulo 2^32).

## Operation
- State: pc[31:0], ir[31:0], FSM {FETCH, HOLD}.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack: ir ← imem_rdata, → HOLD. Without ack: stay, address held stable.
- HOLD: imem_req=0, inst_valid=1. On inst_ready: pc ← next_pc, → FETCH. Without ready: stay; ir and pc unchanged.
- next_pc priority: jump → {pc_plus4[31:28], ir[25:0], 2'b00}; else br_taken → pc_plus4 + {{14{ir[15]}}, ir[15:0], 2'b00}; else pc_plus4. Jump and br_taken both high: jump wins.
- All adds are 32-bit, wrap modulo 2^32, no overflow flag. pc_plus4 at 32'hFFFF_FFFC is 32'h0000_0000.
- ext_sel decode from ir[31:26]: opcodes 0x0C (andi), 0x0D (ori), 0x0E (xori), 0x0F (lui) → 0. All others → 1.
- inst, imm16, ext_sel, pc_plus4 are combinational from ir and pc. They are stable throughout HOLD.
- imem_ack outside FETCH is ignored. br_taken and jump are ignored unless inst_valid & inst_ready.

## Timing
- Reset (rst_n=0 at an edge): pc=RESET_PC, ir=0, state=FETCH. Output values during and after reset: imem_req=0 while rst_n=0; inst_valid=0; inst=0; imm16=0; ext_sel=1; pc_plus4=RESET_PC+4; imem_addr=RESET_PC.
- imem_req rises in the first cycle with rst_n=1.
- Minimum latency from ack to inst_valid is 1 cycle: ack at edge N, inst_valid=1 after edge N.
- Best-case throughput is one instruction per 2 cycles (ack in the first FETCH cycle, ready in the first HOLD cycle).
- Redirected fetch: the new pc appears on imem_addr in the cycle immediately after the acceptance edge.
- Reset mid-fetch or mid-hold: aborts at that edge. A same-cycle imem_ack is discarded and ir stays 0.

## Test plan
- Reset then sequential fetch: RESET_PC default, ack every request, ready always → imem_addr sequence 0x00400000, 0x00400004, 0x00400008; inst_valid alternates 0/1.
- Branch: ir=0x1000FFFE (beq, imm −2) at pc 0x00400010, br_taken=1 → next imem_addr 0x0040000C; same instruction with br_taken=0 → 0x00400014.
- Jump priority: ir=0x08100040 at pc 0x00400020, jump=1 and br_taken=1 → next imem_addr 0x00400100.
- Ext select: ori 0x3421FFFF → imm16=0xFFFF, ext_sel=0; addi 0x2021FFFF → ext_sel=1; lui 0x3C01ABCD → ext_sel=0.
- Backpressure and slow memory: ack delayed 3 cycles → imem_addr stable, imem_req held. inst_ready low 4 cycles → inst and pc unchanged, br_taken toggling ignored.
- Reset mid-operation: rst_n=0 in HOLD with ack asserted → next cycle inst_valid=0, inst=0, imem_addr=RESET_PC. Wrap: pc=0xFFFFFFFC sequential → next imem_addr 0x00000000.
